fifo_mm_writer: RTL and testbench

Drain engine for the showahead FIFO: pops words from a FIFO read port and writes them, one Avalon-MM write per word, into a circular buffer in system memory. It sits between a `fifo_v2`-style FIFO's pop side and the Qsys interconnect as a write master. It publishes a producer index and compares it against a software-owned consumer index, so it never overruns unread data. It raises a level interrupt when buffer occupancy reaches a programmable threshold.

---
 rtl/fifo_mm_pkg.sv | 18 +
 rtl/fifo_mm_ring_idx.sv | 28 ++
 rtl/fifo_mm_writer.sv | 130 +++++++++++++
 tb/tb_fifo_mm_writer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_mm_pkg.sv
// Shared types and helpers for the FIFO-to-memory ring writer and its future ring reader.
package fifo_mm_pkg;

   localparam int DATA_WIDTH     = 32;
   localparam int BYTES_PER_WORD = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      WRITE
   } fifo_mm_state_e;

   // Ring indices are at most 32 bits wide; callers cast to their own index width.
   function automatic logic [31:0] ring_next(input logic [31:0] idx, input logic [31:0] n);
      return (idx == n - 32'd1) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage

// File: rtl/fifo_mm_ring_idx.sv
// Combinational ring bookkeeping: the slot under consideration, its successor, free space and occupancy.
module fifo_mm_ring_idx
   import fifo_mm_pkg::*;
#(
   parameter int IW = 16
) (
   input  logic [IW-1:0] i_wr_idx,
   input  logic [IW-1:0] i_rd_idx,
   input  logic [IW-1:0] i_words,
   input  logic          i_sel_next,
   output logic [IW-1:0] o_slot,
   output logic [IW-1:0] o_slot_next,
   output logic          o_space,
   output logic [IW-1:0] o_occupancy
);

   logic [IW-1:0] w_wr_next;

   always_comb begin
      w_wr_next   = IW'(ring_next(32'(i_wr_idx), 32'(i_words)));
      o_slot      = i_sel_next ? w_wr_next : i_wr_idx;
      o_slot_next = IW'(ring_next(32'(o_slot), 32'(i_words)));
      // One slot is always left empty so that a full ring is distinguishable from an empty one.
      o_space     = (o_slot_next != i_rd_idx);
      o_occupancy = i_wr_idx - i_rd_idx + ((i_wr_idx < i_rd_idx) ? i_words : '0);
   end

endmodule

// File: rtl/fifo_mm_writer.sv
// Drains a showahead FIFO into a circular buffer in system memory, one Avalon-MM write per word.
module fifo_mm_writer
   import fifo_mm_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int AW    = 32,
   parameter int IW    = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 cfg_en_i,
   input  logic [AW-1:0]        cfg_base_i,
   input  logic [IW-1:0]        cfg_words_i,
   input  logic [IW-1:0]        cfg_thresh_i,
   input  logic [IW-1:0]        rd_idx_i,
   input  logic                 fifo_empty_i,
   input  logic [WIDTH-1:0]     fifo_data_i,
   output logic                 fifo_pop_o,
   output logic [AW-1:0]        avm_address_o,
   output logic                 avm_write_o,
   output logic [WIDTH-1:0]     avm_writedata_o,
   output logic [WIDTH/8-1:0]   avm_byteenable_o,
   input  logic                 avm_waitrequest_i,
   output logic [IW-1:0]        wr_idx_o,
   output logic                 busy_o,
   output logic                 irq_o
);

   localparam int BPW = WIDTH / 8;

   fifo_mm_state_e   r_state;
   logic [IW-1:0]    r_wr_idx;
   logic [AW-1:0]    r_addr;
   logic [WIDTH-1:0] r_data;
   logic             r_write;
   logic             r_irq;

   logic [IW-1:0]    w_slot;
   logic [IW-1:0]    w_slot_next;
   logic [IW-1:0]    w_occ;
   logic             w_space;
   logic             w_done;
   logic             w_pop;
   logic             w_to_idle;
   logic             w_irq_hit;
   logic [AW-1:0]    w_addr;
   logic             w_unused;

   fifo_mm_ring_idx #(.IW(IW)) u_ring_idx (
      .i_wr_idx    (r_wr_idx),
      .i_rd_idx    (rd_idx_i),
      .i_words     (cfg_words_i),
      .i_sel_next  (r_state == WRITE),
      .o_slot      (w_slot),
      .o_slot_next (w_slot_next),
      .o_space     (w_space),
      .o_occupancy (w_occ)
   );

   // The successor slot is only needed by the ring reader; the writer relies on the space flag.
   assign w_unused  = ^w_slot_next;

   assign w_done    = (r_state == WRITE) && r_write && !avm_waitrequest_i;
   assign w_pop     = cfg_en_i && !fifo_empty_i && w_space && ((r_state == RUN) || w_done);
   assign w_to_idle = !cfg_en_i && ((r_state == RUN) || w_done);
   assign w_irq_hit = (cfg_thresh_i != '0) && (w_occ >= cfg_thresh_i);
   assign w_addr    = cfg_base_i + AW'(w_slot) * AW'(BPW);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= IDLE;
         r_wr_idx <= '0;
         r_addr   <= '0;
         r_data   <= '0;
         r_write  <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_wr_idx <= '0;
               r_write  <= 1'b0;
               if (cfg_en_i && (cfg_words_i >= IW'(2))) begin
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (w_pop) begin
                  r_addr  <= w_addr;
                  r_data  <= fifo_data_i;
                  r_write <= 1'b1;
                  r_state <= WRITE;
               end else if (w_to_idle) begin
                  r_wr_idx <= '0;
                  r_state  <= IDLE;
               end
            end
            WRITE: begin
               // In WRITE the slot select points at next(wr_idx), which is also the committed index.
               if (w_done) begin
                  if (w_pop) begin
                     r_wr_idx <= w_slot;
                     r_addr   <= w_addr;
                     r_data   <= fifo_data_i;
                  end else if (w_to_idle) begin
                     r_wr_idx <= '0;
                     r_write  <= 1'b0;
                     r_state  <= IDLE;
                  end else begin
                     r_wr_idx <= w_slot;
                     r_write  <= 1'b0;
                     r_state  <= RUN;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
         r_irq <= (r_state != IDLE) && !w_to_idle && w_irq_hit;
      end
   end

   assign fifo_pop_o       = w_pop;
   assign avm_address_o    = r_addr;
   assign avm_write_o      = r_write;
   assign avm_writedata_o  = r_data;
   assign avm_byteenable_o = {BPW{r_write}};
   assign wr_idx_o         = r_wr_idx;
   assign busy_o           = (r_state != IDLE);
   assign irq_o            = r_irq;

endmodule

// File: tb/tb_fifo_mm_writer.sv
// Self-checking bench for fifo_mm_writer: table-driven ring vectors plus hand-written stall, full, irq, disable and reset sequences.
module tb_fifo_mm_writer;
   import fifo_mm_pkg::*;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic [15:0] words;
      logic [31:0] base;
      logic [15:0] rdIdx;
      logic [15:0] thresh;
      int          pushCnt;
      int          expWrites;
      logic [15:0] expWrIdx;
      logic        expIrq;
      logic        expBusy;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        cfgEn;
   logic [31:0] cfgBase;
   logic [15:0] cfgWords;
   logic [15:0] cfgThresh;
   logic [15:0] rdIdx;
   logic        fifoEmpty;
   logic [31:0] fifoData;
   logic        fifoPop;
   logic [31:0] avmAddress;
   logic        avmWrite;
   logic [31:0] avmWritedata;
   logic [3:0]  avmByteenable;
   logic        avmWaitrequest;
   logic [15:0] wrIdx;
   logic        busy;
   logic        irq;

   int   checks = 0;
   int   errors = 0;
   int   writesSeen = 0;
   exp_t expQ[$];
   vec_t vecs[7];

   logic [31:0] fifoMem[64];
   int          fifoHead = 0;
   int          fifoTail = 0;

   fifo_mm_writer #(.WIDTH(32), .AW(32), .IW(16)) dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .cfg_en_i          (cfgEn),
      .cfg_base_i        (cfgBase),
      .cfg_words_i       (cfgWords),
      .cfg_thresh_i      (cfgThresh),
      .rd_idx_i          (rdIdx),
      .fifo_empty_i      (fifoEmpty),
      .fifo_data_i       (fifoData),
      .fifo_pop_o        (fifoPop),
      .avm_address_o     (avmAddress),
      .avm_write_o       (avmWrite),
      .avm_writedata_o   (avmWritedata),
      .avm_byteenable_o  (avmByteenable),
      .avm_waitrequest_i (avmWaitrequest),
      .wr_idx_o          (wrIdx),
      .busy_o            (busy),
      .irq_o             (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Showahead FIFO model feeding the DUT
   assign fifoEmpty = (fifoHead == fifoTail);
   assign fifoData  = fifoMem[fifoHead[5:0]];

   always @(posedge clk) begin
      if (fifoPop) fifoHead <= fifoHead + 1;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Bus monitor and scoreboard: every accepted write is popped against the expected queue
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && avmWrite && !avmWaitrequest) begin
         writesSeen++;
         checkOutput("write expected", 64'(expQ.size() != 0), 64'd1);
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput("write address", 64'(avmAddress), 64'(e.addr));
            checkOutput("write data", 64'(avmWritedata), 64'(e.data));
            checkOutput("byteenable", 64'(avmByteenable), 64'hF);
         end
      end
      if (fifoPop) checkOutput("pop while empty", 64'(fifoEmpty), 64'd0);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic pushWord(input logic [31:0] w);
      fifoMem[fifoTail[5:0]] = w;
      fifoTail = fifoTail + 1;
   endtask

   task automatic setupRing(input logic [15:0] n, input logic [31:0] base, input logic [15:0] rd, input logic [15:0] thr);
      tick(1);
      cfgWords   = n;
      cfgBase    = base;
      rdIdx      = rd;
      cfgThresh  = thr;
      writesSeen = 0;
   endtask

   task automatic teardown();
      tick(1);
      cfgEn          = 1'b0;
      avmWaitrequest = 1'b0;
      tick(3);
      fifoTail = fifoHead;
      rdIdx    = '0;
   endtask

   task automatic waitForWrite(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!avmWrite && n < 20);
      checkOutput(name, 64'(avmWrite), 64'd1);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " address"}, 64'(avmAddress), 64'd0);
      checkOutput({tag, " write"}, 64'(avmWrite), 64'd0);
      checkOutput({tag, " writedata"}, 64'(avmWritedata), 64'd0);
      checkOutput({tag, " byteenable"}, 64'(avmByteenable), 64'd0);
      checkOutput({tag, " wr_idx"}, 64'(wrIdx), 64'd0);
      checkOutput({tag, " busy"}, 64'(busy), 64'd0);
      checkOutput({tag, " irq"}, 64'(irq), 64'd0);
      checkOutput({tag, " pop"}, 64'(fifoPop), 64'd0);
   endtask

   task automatic applyStimulus(input vec_t v, input int id);
      logic [31:0] w;
      setupRing(v.words, v.base, v.rdIdx, v.thresh);
      for (int i = 0; i < v.pushCnt; i++) begin
         w = $urandom;
         pushWord(w);
         if (i < v.expWrites) expQ.push_back('{addr: v.base + 32'(i * BYTES_PER_WORD), data: w});
      end
      cfgEn = 1'b1;
      tick(30);
      @(negedge clk);
      $display("[TB] vector %0d: N=%0d rd=%0d", id, v.words, v.rdIdx);
      checkOutput("vec wr_idx", 64'(wrIdx), 64'(v.expWrIdx));
      checkOutput("vec irq", 64'(irq), 64'(v.expIrq));
      checkOutput("vec busy", 64'(busy), 64'(v.expBusy));
      checkOutput("vec write count", 64'(writesSeen), 64'(v.expWrites));
      checkOutput("vec scoreboard drained", 64'(expQ.size()), 64'd0);
      teardown();
   endtask

   initial begin
      logic [31:0] w0, w1, w2, w3, w4, w5;
      int          n;

      rst_n          = 1'b0;
      cfgEn          = 1'b0;
      cfgBase        = '0;
      cfgWords       = '0;
      cfgThresh      = '0;
      rdIdx          = '0;
      avmWaitrequest = 1'b0;

      //            N      base           rd     thr    push wr  wrIdx  irq   busy
      vecs[0] = '{16'd8,  32'h0000_1000, 16'd0, 16'd3, 3,  3,  16'd3, 1'b1, 1'b1};
      vecs[1] = '{16'd4,  32'h0000_2000, 16'd0, 16'd4, 6,  3,  16'd3, 1'b0, 1'b1};
      vecs[2] = '{16'd2,  32'h0000_0000, 16'd0, 16'd0, 5,  1,  16'd1, 1'b0, 1'b1};
      vecs[3] = '{16'd1,  32'h0000_5000, 16'd0, 16'd1, 2,  0,  16'd0, 1'b0, 1'b0};
      vecs[4] = '{16'd16, 32'hFFFF_FFF8, 16'd0, 16'd2, 4,  4,  16'd4, 1'b1, 1'b1};
      vecs[5] = '{16'd8,  32'h0000_4000, 16'd5, 16'd7, 10, 4,  16'd4, 1'b1, 1'b1};
      vecs[6] = '{16'd5,  32'h0000_3000, 16'd3, 16'd5, 2,  2,  16'd2, 1'b0, 1'b1};

      @(negedge clk);
      checkAllZero("reset");
      tick(1);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

      // Four-cycle stall on the first write: bus held, no second pop, single index step
      $display("[TB] stall sequence");
      setupRing(16'd8, 32'h1000, 16'd0, 16'd0);
      w0 = $urandom;
      w1 = $urandom;
      pushWord(w0);
      pushWord(w1);
      expQ.push_back('{addr: 32'h1000, data: w0});
      expQ.push_back('{addr: 32'h1004, data: w1});
      avmWaitrequest = 1'b1;
      cfgEn = 1'b1;
      waitForWrite("stall first write");
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         checkOutput("stall address", 64'(avmAddress), 64'h1000);
         checkOutput("stall data", 64'(avmWritedata), 64'(w0));
         checkOutput("stall write held", 64'(avmWrite), 64'd1);
         checkOutput("stall no pop", 64'(fifoPop), 64'd0);
         checkOutput("stall wr_idx", 64'(wrIdx), 64'd0);
      end
      tick(1);
      avmWaitrequest = 1'b0;
      @(negedge clk);
      checkOutput("stall fifth address", 64'(avmAddress), 64'h1000);
      checkOutput("stall b2b pop", 64'(fifoPop), 64'd1);
      @(negedge clk);
      checkOutput("stall wr_idx once", 64'(wrIdx), 64'd1);
      checkOutput("stall second address", 64'(avmAddress), 64'h1004);
      @(negedge clk);
      checkOutput("stall wr_idx final", 64'(wrIdx), 64'd2);
      checkOutput("stall write released", 64'(avmWrite), 64'd0);
      teardown();

      // Ring full at N=4, then consumer advance lets slot 3 and slot 0 through
      $display("[TB] ring full sequence");
      setupRing(16'd4, 32'h1000, 16'd0, 16'd0);
      w0 = $urandom; w1 = $urandom; w2 = $urandom;
      w3 = $urandom; w4 = $urandom; w5 = $urandom;
      pushWord(w0); pushWord(w1); pushWord(w2);
      pushWord(w3); pushWord(w4); pushWord(w5);
      expQ.push_back('{addr: 32'h1000, data: w0});
      expQ.push_back('{addr: 32'h1004, data: w1});
      expQ.push_back('{addr: 32'h1008, data: w2});
      cfgEn = 1'b1;
      tick(15);
      @(negedge clk);
      checkOutput("full write count", 64'(writesSeen), 64'd3);
      checkOutput("full wr_idx", 64'(wrIdx), 64'd3);
      checkOutput("full fifo nonempty", 64'(fifoEmpty), 64'd0);
      checkOutput("full no pop", 64'(fifoPop), 64'd0);
      expQ.push_back('{addr: 32'h100C, data: w3});
      expQ.push_back('{addr: 32'h1000, data: w4});
      tick(1);
      rdIdx = 16'd2;
      tick(15);
      @(negedge clk);
      checkOutput("refill write count", 64'(writesSeen), 64'd5);
      checkOutput("refill wr_idx", 64'(wrIdx), 64'd1);
      checkOutput("refill scoreboard drained", 64'(expQ.size()), 64'd0);
      teardown();

      // Interrupt one cycle after wr_idx reaches the threshold, cleared by consumer advance
      $display("[TB] irq sequence");
      setupRing(16'd8, 32'h1000, 16'd0, 16'd2);
      w0 = $urandom;
      w1 = $urandom;
      pushWord(w0);
      pushWord(w1);
      expQ.push_back('{addr: 32'h1000, data: w0});
      expQ.push_back('{addr: 32'h1004, data: w1});
      cfgEn = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (wrIdx != 16'd2 && n < 20);
      checkOutput("irq wr_idx reached", 64'(wrIdx), 64'd2);
      checkOutput("irq latency low", 64'(irq), 64'd0);
      @(negedge clk);
      checkOutput("irq raised", 64'(irq), 64'd1);
      tick(1);
      rdIdx = 16'd1;
      @(negedge clk);
      checkOutput("irq still high", 64'(irq), 64'd1);
      @(negedge clk);
      checkOutput("irq cleared", 64'(irq), 64'd0);
      teardown();

      // Enable dropped during a stalled write: write completes, then IDLE with data left in FIFO
      $display("[TB] disable sequence");
      setupRing(16'd8, 32'h1000, 16'd0, 16'd0);
      w0 = $urandom;
      pushWord(w0);
      pushWord($urandom);
      pushWord($urandom);
      expQ.push_back('{addr: 32'h1000, data: w0});
      avmWaitrequest = 1'b1;
      cfgEn = 1'b1;
      waitForWrite("disable first write");
      tick(1);
      cfgEn = 1'b0;
      @(negedge clk);
      checkOutput("disable busy held", 64'(busy), 64'd1);
      checkOutput("disable write held", 64'(avmWrite), 64'd1);
      tick(1);
      avmWaitrequest = 1'b0;
      @(negedge clk);
      checkOutput("disable no pop", 64'(fifoPop), 64'd0);
      @(negedge clk);
      checkOutput("disable busy fell", 64'(busy), 64'd0);
      checkOutput("disable wr_idx cleared", 64'(wrIdx), 64'd0);
      checkOutput("disable write released", 64'(avmWrite), 64'd0);
      checkOutput("disable fifo untouched", 64'(fifoEmpty), 64'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput("disable idle no pop", 64'(fifoPop), 64'd0);
      end
      checkOutput("disable write count", 64'(writesSeen), 64'd1);
      teardown();

      // Asynchronous reset during a stalled write releases the bus without a clock edge
      $display("[TB] reset sequence");
      setupRing(16'd8, 32'h1000, 16'd0, 16'd1);
      for (int k = 0; k < 4; k++) pushWord($urandom);
      avmWaitrequest = 1'b1;
      cfgEn = 1'b1;
      waitForWrite("reset first write");
      tick(1);
      rst_n = 1'b0;
      #1;
      checkAllZero("async reset");
      tick(1);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post reset idle", 64'(busy), 64'd0);
      checkOutput("reset write count", 64'(writesSeen), 64'd0);
      teardown();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
